rf80386_icache: RTL and testbench
=================================

# rf80386_icache

Two-bank instruction cache sitting directly upstream of the rf80386 core. It accepts the core's linear fetch address `csip` and returns a 128-bit instruction bundle `ibundle` whose byte 0 is the byte at `csip`, with `ihit` qualifying it. Misses are filled from memory over the FTA 128-bit bus using its own master channel. Even/odd 16-byte line banks let a bundle that straddles two lines be delivered in one cycle.

## Interface
- `CORENO`, 6'd1, core number placed in `ftam_req.tid.core`
- `CID`, 3'd2, channel id placed in `ftam_req.tid.channel`; must differ from the core's data channel
- `LINES`, 64, lines per bank (power of two); total capacity 2×LINES×16 B
- `clk_i` in 1: single clock
- `rst_i` in 1: synchronous, active-high reset
- `csip` in 32: fetch address from the core
- `inv_i` in 1: invalidate all lines (one-cycle pulse)
- `ibundle` out 128: bytes csip..csip+15, little-endian; ibundle[7:0] = byte at csip
- `ihit` out 1: ibundle valid for current csip
- `ftam_req` out fta_cmd_request128_t: line-fill request
- `ftam_resp` in fta_cmd_response128_t: fill response (`ack`, `rty`, `dat`, `tid`)

## Operation
- Line A = csip[31:4], line B = A+1 (32-bit wrap: csip=FFFF_FFF8h gives B=0). Exactly one is even (bit 0 = 0) and maps to the even bank, the other to the odd bank.
- Bank index = line[log2(LINES):1]; tag = line[27:log2(LINES)+1]; one valid bit per entry.
- ihit = A hit AND B hit. ibundle = {lineB,lineA} >> (csip[3:0]×8), low 128 bits. When ihit=0, ibundle holds the same computed value (don't care to the core).
- FSM states (package enum `icache_state_t`): IDLE, REQ, WAIT, RTY_WAIT.
- IDLE: if !ihit, latch fill line = A if A misses else B; go REQ.
- REQ (one cycle): cyc=stb=1, we=0, cmd=CMD_LOAD, sel=16'hFFFF, adr={fill_line,4'h0}, tranid from tid counter (1..15, wraps 15→1, never 0); go WAIT.
- WAIT: on ack with matching tid, write dat into the bank/index of fill line, set tag and valid; go IDLE. On rty with matching tid go RTY_WAIT. Responses with non-matching tid are ignored.
- RTY_WAIT: count 16 cycles, then REQ with a fresh tid.
- All non-REQ cycles drive ftam_req to the cleared value (cmd=CMD_NONE, cyc/stb/we=0, sel=0, tranid=0); core/channel fields are constant.
- csip change mid-fill: the fill in progress completes for the latched line; the new csip is evaluated on return to IDLE.
- inv_i: clears all valid bits that cycle. If asserted in WAIT/RTY_WAIT, the in-flight line is written but not marked valid. If inv_i coincides with the ack-write cycle, inv_i wins.
- Reset: all valid bits 0, state IDLE, tid=1, ftam_req cleared, so ihit=0. Reset mid-fill abandons the fill; a late ack is ignored because state is IDLE.

## Timing
- Hit: combinational; ihit/ibundle valid in the same cycle as csip (async-read tag/valid/data arrays).
- Miss detect → REQ: 1 cycle. Request pulse: exactly 1 cycle.
- Ack cycle N: line written at edge ending N; ihit rises in N+1 if the other line was already present.
- Straddling double miss: two sequential fills, line A first.
- Retry: re-request 17 cycles after rty (16 wait + REQ).

## Structure
- In `rf80386_pkg`: `icache_state_t`, `ICACHE_LINE_BYTES`=16, `ICACHE_RTY_WAIT`=16.
- Sub-module `rf80386_icache_bank` (instantiated twice: even, odd): LINES×(valid+tag+128 data), async read, one sync write port, synchronous clear-all.
- Uses `fta_bus_pkg` request/response types unchanged.

## Test plan
- Reset, csip=000F_0000h -> ihit=0; REQ adr=000F_0000h tranid=1; ack dat=D0 -> next REQ adr=000F_0010h tranid=2; ack -> ihit=1, ibundle=D0.
- After fill, csip=000F_0008h -> ihit=1 same cycle, ibundle={D1[63:0],D0[127:64]}; no bus activity.
- csip=FFFF_FFF8h -> fills FFFF_FFF0h then 0000_0000h; ibundle low 8 bytes from first, high 8 from second.
- rty on tranid=3 -> cyc low 16 cycles, REQ reissued with tranid=4 same adr; stray ack with tranid=3 ignored.
- inv_i during WAIT -> after ack ihit remains 0 and line re-requested; tid 15 → next 1.
- rst_i asserted in WAIT, ack arrives after reset -> no valid bits set, ihit=0, ftam_req cleared.

Source files
------------

// File: rtl/fta_bus_pkg.sv
// FTA 128-bit bus request/response types shared by every master and slave
// on the bus.
//   fta_cmd_request128_t  : command, strobes, byte selects, address, write
//                           data and transaction id driven by a master.
//   fta_cmd_response128_t : ack/rty qualifiers, read data and the echoed
//                           transaction id returned by a slave.
package fta_bus_pkg;

  typedef enum logic [4:0] {
    CMD_NONE  = 5'd0,
    CMD_LOAD  = 5'd1,
    CMD_LOADZ = 5'd2,
    CMD_STORE = 5'd3
  } fta_cmd_t;

  typedef logic [3:0] fta_tranid_t;

  typedef struct packed {
    logic [5:0]  core;
    logic [2:0]  channel;
    fta_tranid_t tranid;
  } fta_tid_t;

  typedef struct packed {
    fta_cmd_t     cmd;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    fta_tid_t     tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic [127:0] dat;
    fta_tid_t     tid;
  } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// Shared definitions for the rf80386 instruction cache: fill FSM state
// encoding, line size, retry back-off length and the transaction-id
// sequencing helper.
package rf80386_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT     = 2'd2,
    RTY_WAIT = 2'd3
  } icache_state_t;

  localparam int unsigned ICACHE_LINE_BYTES = 16;
  localparam int unsigned ICACHE_RTY_WAIT   = 16;

  // Transaction ids run 1..15; 0 is never issued.
  function automatic logic [3:0] icache_next_tid(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/rf80386_icache_bank.sv
// One bank (even or odd lines) of the rf80386 instruction cache.
//   clk_i, rst_i : clock, synchronous active-high reset (clears valids)
//   clr_i        : clear every valid bit this cycle (wins over a write)
//   rd_idx       : asynchronous read index -> rd_valid, rd_tag, rd_data
//   we_i, wr_*   : single synchronous write port (valid, tag, 128-bit data)
module rf80386_icache_bank #(
  parameter int unsigned LINES = 64,
  parameter int unsigned IDXW  = $clog2(LINES),
  parameter int unsigned TAGW  = 27 - IDXW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [127:0]    rd_data,
  input  logic            we_i,
  input  logic [IDXW-1:0] wr_idx,
  input  logic            wr_valid,
  input  logic [TAGW-1:0] wr_tag,
  input  logic [127:0]    wr_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (we_i)  valid_d[wr_idx] = wr_valid;
    if (clr_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag/data need no reset: an entry is meaningless until its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/rf80386_icache.sv
// rf80386 two-bank instruction cache.
//   clk_i, rst_i : clock, synchronous active-high reset
//   csip         : linear fetch address from the core
//   inv_i        : invalidate every line (one-cycle pulse)
//   ibundle      : 16 bytes starting at csip, byte 0 in ibundle[7:0]
//   ihit         : ibundle valid for the current csip
//   ftam_req     : FTA master request used for line fills
//   ftam_resp    : FTA response carrying fill data
// Lines csip[31:4] and csip[31:4]+1 are looked up in parallel, one in the
// even bank and one in the odd bank, so a straddling fetch hits in one cycle.
module rf80386_icache
  import fta_bus_pkg::*;
  import rf80386_pkg::*;
#(
  parameter logic [5:0]  CORENO = 6'd1,
  parameter logic [2:0]  CID    = 3'd2,
  parameter int unsigned LINES  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          csip,
  input  logic                 inv_i,
  output logic [127:0]         ibundle,
  output logic                 ihit,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp
);

  localparam int unsigned IDXW = $clog2(LINES);
  localparam int unsigned TAGW = 27 - IDXW;

  icache_state_t state_q, state_d;
  logic [27:0]   fill_line_q, fill_line_d;
  logic [3:0]    tid_q, tid_d;
  logic [3:0]    rty_cnt_q, rty_cnt_d;
  logic          kill_q, kill_d;

  logic [27:0]   line_a, line_b, even_line, odd_line;
  logic          a_odd;
  logic          even_valid, odd_valid, even_hit, odd_hit, a_hit, b_hit;
  logic [TAGW-1:0] even_tag, odd_tag;
  logic [127:0]  even_data, odd_data, data_a, data_b;
  logic          wr_en, wr_valid, resp_match;

  assign line_a    = csip[31:4];
  assign line_b    = line_a + 28'd1;
  assign a_odd     = line_a[0];
  assign even_line = a_odd ? line_b : line_a;
  assign odd_line  = a_odd ? line_a : line_b;

  rf80386_icache_bank #(.LINES(LINES), .IDXW(IDXW), .TAGW(TAGW)) u_even (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (inv_i),
    .rd_idx   (even_line[IDXW:1]),
    .rd_valid (even_valid),
    .rd_tag   (even_tag),
    .rd_data  (even_data),
    .we_i     (wr_en & ~fill_line_q[0]),
    .wr_idx   (fill_line_q[IDXW:1]),
    .wr_valid (wr_valid),
    .wr_tag   (fill_line_q[27:IDXW+1]),
    .wr_data  (ftam_resp.dat)
  );

  rf80386_icache_bank #(.LINES(LINES), .IDXW(IDXW), .TAGW(TAGW)) u_odd (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (inv_i),
    .rd_idx   (odd_line[IDXW:1]),
    .rd_valid (odd_valid),
    .rd_tag   (odd_tag),
    .rd_data  (odd_data),
    .we_i     (wr_en & fill_line_q[0]),
    .wr_idx   (fill_line_q[IDXW:1]),
    .wr_valid (wr_valid),
    .wr_tag   (fill_line_q[27:IDXW+1]),
    .wr_data  (ftam_resp.dat)
  );

  assign even_hit = even_valid && (even_tag == even_line[27:IDXW+1]);
  assign odd_hit  = odd_valid  && (odd_tag  == odd_line[27:IDXW+1]);
  assign a_hit    = a_odd ? odd_hit  : even_hit;
  assign b_hit    = a_odd ? even_hit : odd_hit;
  assign data_a   = a_odd ? odd_data  : even_data;
  assign data_b   = a_odd ? even_data : odd_data;

  assign ihit    = a_hit & b_hit;
  assign ibundle = 128'({data_b, data_a} >> {csip[3:0], 3'b000});

  assign resp_match = (ftam_resp.tid == {CORENO, CID, tid_q});
  // An invalidate seen at any point during the fill, or on the ack cycle
  // itself, leaves the written line invalid.
  assign wr_valid   = ~kill_q & ~inv_i;

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    tid_d       = tid_q;
    rty_cnt_d   = rty_cnt_q;
    kill_d      = kill_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ihit) begin
          fill_line_d = a_hit ? line_b : line_a;
          kill_d      = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (ftam_resp.ack && resp_match) begin
          wr_en   = 1'b1;
          tid_d   = icache_next_tid(tid_q);
          state_d = IDLE;
        end else if (ftam_resp.rty && resp_match) begin
          tid_d     = icache_next_tid(tid_q);
          rty_cnt_d = '0;
          state_d   = RTY_WAIT;
        end
      end
      RTY_WAIT: begin
        if (rty_cnt_q == 4'(ICACHE_RTY_WAIT - 1)) state_d = REQ;
        else rty_cnt_d = rty_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (inv_i && state_q != IDLE) kill_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fill_line_q <= '0;
      tid_q       <= 4'd1;
      rty_cnt_q   <= '0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      tid_q       <= tid_d;
      rty_cnt_q   <= rty_cnt_d;
      kill_q      <= kill_d;
    end
  end

  always_comb begin
    ftam_req             = '0;
    ftam_req.cmd         = CMD_NONE;
    ftam_req.tid.core    = CORENO;
    ftam_req.tid.channel = CID;
    if (state_q == REQ) begin
      ftam_req.cmd        = CMD_LOAD;
      ftam_req.cyc        = 1'b1;
      ftam_req.stb        = 1'b1;
      ftam_req.we         = 1'b0;
      ftam_req.sel        = '1;
      ftam_req.adr        = {fill_line_q, 4'h0};
      ftam_req.tid.tranid = tid_q;
    end
  end

endmodule

// File: tb/tb_rf80386_icache.sv
module tb_rf80386_icache;
  import fta_bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 inv_i;
  logic [31:0]          csip;
  logic [127:0]         ibundle;
  logic                 ihit;
  fta_cmd_request128_t  ftam_req;
  fta_cmd_response128_t ftam_resp;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  tranid;
  } req_t;
  req_t exp_q[$];

  typedef struct {
    logic [31:0]  csip;
    logic         hit;
    logic [127:0] bundle;
  } vec_t;

  fta_cmd_request128_t clr_req;

  always #5 clk = ~clk;

  rf80386_icache #(.CORENO(6'd1), .CID(3'd2), .LINES(64)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .csip      (csip),
    .inv_i     (inv_i),
    .ibundle   (ibundle),
    .ihit      (ihit),
    .ftam_req  (ftam_req),
    .ftam_resp (ftam_resp)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ldat(input logic [27:0] l);
    logic [127:0] r;
    logic [31:0]  t;
    for (int k = 0; k < 4; k++) begin
      t = {l, 4'(k)};
      r[k*32 +: 32] = t ^ {t[15:0], t[31:16]} ^ 32'h5A5A_3C3C;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_bundle(input logic [127:0] d0, input logic [127:0] d1,
                                              input int k);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) begin
      if (j + k < 16) r[j*8 +: 8] = d0[(j+k)*8 +: 8];
      else            r[j*8 +: 8] = d1[(j+k-16)*8 +: 8];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic find_req(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      if (ftam_req.cyc === 1'b1) begin
        n = i;
        return;
      end
      step();
    end
    n_tests++;
    n_fail++;
    $display("FAIL req_timeout: got no request want request within 40 cycles");
  endtask

  task automatic check_req();
    req_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got request adr %h want none", ftam_req.adr);
      return;
    end
    e = exp_q.pop_front();
    check("req_adr", ftam_req.adr, e.adr);
    check("req_tranid", ftam_req.tid.tranid, e.tranid);
    check("req_cmd", ftam_req.cmd, CMD_LOAD);
    check("req_sel", ftam_req.sel, 16'hFFFF);
    check("req_stb_we", {ftam_req.stb, ftam_req.we}, 2'b10);
  endtask

  task automatic pulse_resp(input bit is_ack, input logic [3:0] tid, input logic [127:0] d,
                            input bit inv);
    ftam_resp            = '0;
    ftam_resp.ack        = is_ack;
    ftam_resp.rty        = ~is_ack;
    ftam_resp.tid        = {6'd1, 3'd2, tid};
    ftam_resp.dat        = d;
    inv_i                = inv;
    step();
    ftam_resp = '0;
    inv_i     = 1'b0;
    #1;
  endtask

  task automatic respond(input bit is_ack, input logic [3:0] tid, input logic [127:0] d,
                         input bit inv);
    step();
    check("req_pulse_1cyc", ftam_req.cyc, 1'b0);
    pulse_resp(is_ack, tid, d, inv);
  endtask

  task automatic fill(input logic [31:0] adr, input logic [3:0] tid, output int n);
    req_t e;
    e.adr = adr;
    e.tranid = tid;
    exp_q.push_back(e);
    find_req(n);
    check_req();
    respond(1'b1, tid, ldat(adr[31:4]), 1'b0);
  endtask

  initial begin
    int           n;
    req_t         e;
    vec_t         vt[6];
    int           ks[6];
    logic [127:0] d0, d1;

    clr_req             = '0;
    clr_req.cmd         = CMD_NONE;
    clr_req.tid.core    = 6'd1;
    clr_req.tid.channel = 3'd2;

    ftam_resp = '0;
    inv_i     = 1'b0;
    rst_i     = 1'b1;
    csip      = 32'h000F_0000;
    step();
    step();
    #1;
    check("rst_ihit", ihit, 1'b0);
    check("rst_req_cleared", ftam_req, clr_req);
    rst_i = 1'b0;

    // First straddle-free fetch: two sequential fills, line A then B.
    e.adr = 32'h000F_0000; e.tranid = 4'd1; exp_q.push_back(e);
    find_req(n);
    check("miss_to_req_latency", n, 1);
    check_req();
    respond(1'b1, 4'd1, ldat(28'h000_F000), 1'b0);
    check("half_fill_ihit", ihit, 1'b0);
    fill(32'h000F_0010, 4'd2, n);
    check("second_fill_latency", n, 1);
    check("fill_ihit", ihit, 1'b1);
    check("fill_bundle", ibundle, ldat(28'h000_F000));

    // Hit vectors across the two filled lines.
    d0 = ldat(28'h000_F000);
    d1 = ldat(28'h000_F001);
    ks = '{0, 1, 7, 8, 12, 15};
    for (int i = 0; i < 6; i++) begin
      vt[i].csip   = 32'h000F_0000 + 32'(ks[i]);
      vt[i].hit    = 1'b1;
      vt[i].bundle = exp_bundle(d0, d1, ks[i]);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      csip = vt[i].csip;
      #1;
      check("vec_ihit", ihit, vt[i].hit);
      check("vec_bundle", ibundle, vt[i].bundle);
      check("vec_no_bus", ftam_req.cyc, 1'b0);
    end
    step();
    csip = 32'h000F_0008;
    #1;
    check("offset8_bundle", ibundle, {d1[63:0], d0[127:64]});
    step();
    check("hit_no_bus", ftam_req, clr_req);

    // Retry, back-off length and a stray ack with the stale id.
    csip = 32'h0002_0040;
    e.adr = 32'h0002_0040; e.tranid = 4'd3; exp_q.push_back(e);
    find_req(n);
    check_req();
    respond(1'b0, 4'd3, '0, 1'b0);
    e.adr = 32'h0002_0040; e.tranid = 4'd4; exp_q.push_back(e);
    find_req(n);
    check("rty_gap", n, 16);
    check_req();
    respond(1'b1, 4'd3, ~ldat(28'h000_2004), 1'b0);
    for (int j = 0; j < 3; j++) begin
      check("stray_ack_ignored", ftam_req.cyc, 1'b0);
      check("stray_ack_ihit", ihit, 1'b0);
      step();
    end
    pulse_resp(1'b1, 4'd4, ldat(28'h000_2004), 1'b0);
    fill(32'h0002_0050, 4'd5, n);
    check("rty_fill_ihit", ihit, 1'b1);
    check("rty_fill_bundle", ibundle, ldat(28'h000_2004));

    // 32-bit wrap straddle.
    step();
    csip = 32'hFFFF_FFF8;
    #1;
    fill(32'hFFFF_FFF0, 4'd6, n);
    check("wrap_half_ihit", ihit, 1'b0);
    fill(32'h0000_0000, 4'd7, n);
    check("wrap_ihit", ihit, 1'b1);
    d0 = ldat(28'hFFF_FFFF);
    d1 = ldat(28'h000_0000);
    check("wrap_bundle", ibundle, {d1[63:0], d0[127:64]});

    // Invalidate while the fill is outstanding.
    step();
    csip = 32'h0003_0080;
    e.adr = 32'h0003_0080; e.tranid = 4'd8; exp_q.push_back(e);
    find_req(n);
    check_req();
    step();
    inv_i = 1'b1;
    step();
    inv_i = 1'b0;
    #1;
    pulse_resp(1'b1, 4'd8, ldat(28'h000_3008), 1'b0);
    check("inv_wait_ihit", ihit, 1'b0);
    fill(32'h0003_0080, 4'd9, n);
    fill(32'h0003_0090, 4'd10, n);
    check("inv_refill_ihit", ihit, 1'b1);
    step();
    csip = 32'h000F_0000;
    #1;
    check("inv_cleared_old", ihit, 1'b0);
    fill(32'h000F_0000, 4'd11, n);
    fill(32'h000F_0010, 4'd12, n);
    step();
    csip = 32'hFFFF_FFF8;
    #1;
    fill(32'hFFFF_FFF0, 4'd13, n);
    fill(32'h0000_0000, 4'd14, n);

    // Invalidate coinciding with the ack, and tid wrap 15 -> 1.
    step();
    csip = 32'h0004_0000;
    e.adr = 32'h0004_0000; e.tranid = 4'd15; exp_q.push_back(e);
    find_req(n);
    check_req();
    respond(1'b1, 4'd15, ldat(28'h000_4000), 1'b1);
    check("inv_with_ack_ihit", ihit, 1'b0);
    fill(32'h0004_0000, 4'd1, n);
    fill(32'h0004_0010, 4'd2, n);
    check("wrap_tid_ihit", ihit, 1'b1);
    check("wrap_tid_bundle", ibundle, ldat(28'h000_4000));

    // Reset in WAIT with a late ack afterwards.
    step();
    csip = 32'h0005_0000;
    e.adr = 32'h0005_0000; e.tranid = 4'd3; exp_q.push_back(e);
    find_req(n);
    check_req();
    step();
    rst_i = 1'b1;
    csip  = 32'h0004_0000;
    step();
    check("rst_mid_valid_clear", ihit, 1'b0);
    check("rst_mid_req_cleared", ftam_req, clr_req);
    step();
    rst_i         = 1'b0;
    csip          = 32'h0005_0000;
    ftam_resp     = '0;
    ftam_resp.ack = 1'b1;
    ftam_resp.tid = {6'd1, 3'd2, 4'd3};
    ftam_resp.dat = ldat(28'h000_5000);
    step();
    ftam_resp = '0;
    #1;
    check("late_ack_ihit", ihit, 1'b0);
    e.adr = 32'h0005_0000; e.tranid = 4'd1; exp_q.push_back(e);
    find_req(n);
    check("post_rst_req_latency", n, 0);
    check_req();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
